// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO and a configurable frame format
// (DATA_BITS data bits LSB first, optional odd/even parity, 1 or 2 stop bits).
// Queued words go out back-to-back with no idle gap between frames.
module uart_tx_fifo #(
  parameter int CLK_PER_BIT = 100,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_BITS-1:0]          TXDATA,
  input  logic                          TXVALID,
  output logic                          TXREADY,
  output logic                          UARTTX,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(CLK_PER_BIT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [AW:0]          r_count;
  logic [2:0]           r_state;
  logic [TW-1:0]        r_timer;
  logic [3:0]           r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_par;

  logic                 w_push, w_pop, w_bit_end, w_last_stop, w_par;
  logic [DATA_BITS-1:0] w_rd_data;

  assign TXREADY     = !RST && (r_count < (AW+1)'(FIFO_DEPTH));
  assign FIFO_COUNT  = r_count;
  assign w_push      = TXVALID && TXREADY;
  assign w_bit_end   = (r_timer == TW'(CLK_PER_BIT-1));
  assign w_last_stop = (r_state == S_STOP) && w_bit_end && (r_stop_idx == 1'(STOP_BITS-1));
  // A new word leaves the FIFO when the line is idle, or exactly when the
  // final stop bit ends so the next start bit follows without a gap.
  assign w_pop       = (r_count != '0) && ((r_state == S_IDLE) || w_last_stop);
  assign w_rd_data   = r_mem[r_rd_ptr];
  // Parity bit value is fixed at pop time so the shifter can be consumed freely.
  assign w_par       = (PARITY == 1) ? ~(^w_rd_data) : ^w_rd_data;

  // FIFO storage; contents need no reset since count/pointers gate reads.
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= TXDATA;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Frame FSM: every bit lasts CLK_PER_BIT cycles; the next bit is driven on
  // the terminal-count edge of the current one.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shreg    <= '0;
      r_par      <= 1'b0;
      UARTTX     <= 1'b1;
      BUSY       <= 1'b0;
    end else if (r_state == S_IDLE) begin
      UARTTX <= 1'b1;
      if (w_pop) begin
        r_shreg <= w_rd_data;
        r_par   <= w_par;
        r_timer <= '0;
        UARTTX  <= 1'b0;
        BUSY    <= 1'b1;
        r_state <= S_START;
      end
    end else if (!w_bit_end) begin
      r_timer <= r_timer + 1'b1;
    end else begin
      r_timer <= '0;
      case (r_state)
        S_START: begin
          UARTTX    <= r_shreg[0];
          r_shreg   <= r_shreg >> 1;
          r_bit_idx <= '0;
          r_state   <= S_DATA;
        end
        S_DATA: begin
          if (r_bit_idx == 4'(DATA_BITS-1)) begin
            if (PARITY != 0) begin
              UARTTX  <= r_par;
              r_state <= S_PAR;
            end else begin
              UARTTX     <= 1'b1;
              r_stop_idx <= 1'b0;
              r_state    <= S_STOP;
            end
          end else begin
            UARTTX    <= r_shreg[0];
            r_shreg   <= r_shreg >> 1;
            r_bit_idx <= r_bit_idx + 1'b1;
          end
        end
        S_PAR: begin
          UARTTX     <= 1'b1;
          r_stop_idx <= 1'b0;
          r_state    <= S_STOP;
        end
        S_STOP: begin
          if (!w_last_stop) begin
            r_stop_idx <= 1'b1;
          end else if (w_pop) begin
            r_shreg <= w_rd_data;
            r_par   <= w_par;
            UARTTX  <= 1'b0;
            r_state <= S_START;
          end else begin
            UARTTX  <= 1'b1;
            BUSY    <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          UARTTX  <= 1'b1;
          BUSY    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1, 8E1, 8O2) at 4 clocks/bit,
// compared cycle by cycle against a frame-offset reference model.
module tb_uart_tx_fifo;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [7:0] txd = 8'h00;
  logic       v    [3] = '{1'b0, 1'b0, 1'b0};
  logic       rdy  [3];
  logic       tx   [3];
  logic       busy [3];
  logic [2:0] cnt  [3];

  int n_chk = 0;
  int n_err = 0;

  uart_tx_fifo #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .CLK(clk), .RST(rst), .TXDATA(txd), .TXVALID(v[0]), .TXREADY(rdy[0]),
    .UARTTX(tx[0]), .BUSY(busy[0]), .FIFO_COUNT(cnt[0]));
  uart_tx_fifo #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .CLK(clk), .RST(rst), .TXDATA(txd), .TXVALID(v[1]), .TXREADY(rdy[1]),
    .UARTTX(tx[1]), .BUSY(busy[1]), .FIFO_COUNT(cnt[1]));
  uart_tx_fifo #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
    .CLK(clk), .RST(rst), .TXDATA(txd), .TXVALID(v[2]), .TXREADY(rdy[2]),
    .UARTTX(tx[2]), .BUSY(busy[2]), .FIFO_COUNT(cnt[2]));

  // Reference model: a word queue per instance plus the cycle offset into the
  // frame on the wire (-1 when idle). The line level is the frame bit at
  // offset/CPB.
  logic [7:0] mw   [3][64];
  int         mh   [3] = '{0, 0, 0};
  int         mt   [3] = '{0, 0, 0};
  int         mc   [3] = '{-1, -1, -1};
  logic [7:0] mcur [3];
  bit         mpushed [3];

  function automatic int par_of(int d);
    return (d == 0) ? 0 : (d == 1) ? 2 : 1;
  endfunction

  function automatic int stop_of(int d);
    return (d == 2) ? 2 : 1;
  endfunction

  function automatic int flen(int d);
    return CPB * (1 + 8 + ((par_of(d) != 0) ? 1 : 0) + stop_of(d));
  endfunction

  function automatic logic exp_line(int d);
    int b;
    if (mc[d] < 0) return 1'b1;
    b = mc[d] / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return mcur[d][b-1];
    if (par_of(d) != 0 && b == 9) return (par_of(d) == 2) ? ^mcur[d] : ~(^mcur[d]);
    return 1'b1;
  endfunction

  function automatic logic [5:0] want(int d);
    int n;
    n = mt[d] - mh[d];
    return {exp_line(d), (mc[d] >= 0), 3'(n), (!rst && n < 4)};
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 3; d++) begin
      bit pop, push;
      mpushed[d] = 1'b0;
      if (rst) begin
        mh[d] = 0; mt[d] = 0; mc[d] = -1;
      end else begin
        pop  = (mt[d] - mh[d] > 0) && (mc[d] < 0 || mc[d] == flen(d) - 1);
        push = v[d] && (mt[d] - mh[d] < 4);
        if (pop) begin mcur[d] = mw[d][mh[d] % 64]; mh[d]++; end
        if (push) begin mw[d][mt[d] % 64] = txd; mt[d]++; mpushed[d] = 1'b1; end
        if (pop) mc[d] = 0;
        else if (mc[d] >= 0) begin
          mc[d]++;
          if (mc[d] == flen(d)) mc[d] = -1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_chk++;
    if ({tx[0], busy[0], cnt[0], rdy[0]} !== 6'b100000) begin
      n_err++; $display("FAIL reset_state got=%b exp=%b", {tx[0], busy[0], cnt[0], rdy[0]}, 6'b100000);
    end
    rst = 1'b0;
    step();
    n_chk++;
    if (rdy[0] !== 1'b1) begin n_err++; $display("FAIL ready_after_reset got=%b exp=1", rdy[0]); end
  endtask

  task automatic test_frame_8n1();
    logic [9:0] pat;
    int nb;
    pat = 10'b1101001010;
    nb = 0;
    txd = 8'hA5; v[0] = 1'b1;
    step();
    v[0] = 1'b0;
    n_chk++;
    if (cnt[0] !== 3'd1) begin n_err++; $display("FAIL count_after_push got=%0d exp=1", cnt[0]); end
    for (int i = 0; i < 45; i++) begin
      step();
      if (busy[0]) nb++;
      n_chk++;
      if ({tx[0], busy[0], cnt[0], rdy[0]} !== want(0)) begin
        n_err++; $display("FAIL frame_8n1 cyc=%0d got=%b exp=%b", i, {tx[0], busy[0], cnt[0], rdy[0]}, want(0));
      end
      if (i < 40 && i % CPB == 2) begin
        n_chk++;
        if (tx[0] !== pat[i/CPB]) begin
          n_err++; $display("FAIL a5_bit%0d got=%b exp=%b", i / CPB, tx[0], pat[i/CPB]);
        end
      end
    end
    n_chk++;
    if (nb != 40) begin n_err++; $display("FAIL busy_len_8n1 got=%0d exp=40", nb); end
  endtask

  task automatic test_parity();
    int nb1, nb2;
    nb1 = 0; nb2 = 0;
    txd = 8'hA5; v[1] = 1'b1; v[2] = 1'b1;
    step();
    v[1] = 1'b0; v[2] = 1'b0;
    for (int i = 0; i < 52; i++) begin
      step();
      if (busy[1]) nb1++;
      if (busy[2]) nb2++;
      for (int d = 1; d < 3; d++) begin
        n_chk++;
        if ({tx[d], busy[d], cnt[d], rdy[d]} !== want(d)) begin
          n_err++; $display("FAIL parity_frame u%0d cyc=%0d got=%b exp=%b", d, i, {tx[d], busy[d], cnt[d], rdy[d]}, want(d));
        end
      end
      if (i == 38) begin
        n_chk++;
        if ({tx[1], tx[2]} !== 2'b01) begin
          n_err++; $display("FAIL parity_bit even/odd got=%b exp=01", {tx[1], tx[2]});
        end
      end
    end
    n_chk++;
    if (nb1 != 44 || nb2 != 48) begin
      n_err++; $display("FAIL busy_len_parity got=%0d/%0d exp=44/48", nb1, nb2);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] seq [3];
    int nb;
    seq = '{3'd1, 3'd1, 3'd2};
    nb = 0;
    v[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      txd = 8'(k + 1);
      step();
      if (busy[0]) nb++;
      n_chk++;
      if (cnt[0] !== seq[k]) begin n_err++; $display("FAIL b2b_count%0d got=%0d exp=%0d", k, cnt[0], seq[k]); end
    end
    v[0] = 1'b0;
    for (int i = 0; i < 130; i++) begin
      step();
      if (busy[0]) nb++;
      n_chk++;
      if ({tx[0], busy[0], cnt[0], rdy[0]} !== want(0)) begin
        n_err++; $display("FAIL b2b cyc=%0d got=%b exp=%b", i, {tx[0], busy[0], cnt[0], rdy[0]}, want(0));
      end
    end
    n_chk++;
    if (nb != 120) begin n_err++; $display("FAIL b2b_busy_len got=%0d exp=120", nb); end
  endtask

  task automatic test_fill();
    logic [7:0] w [7];
    int idx;
    idx = 0;
    for (int k = 0; k < 7; k++) w[k] = 8'($urandom);
    for (int i = 0; i < 300; i++) begin
      v[0] = (idx < 7);
      txd  = w[(idx < 7) ? idx : 0];
      step();
      if (mpushed[0]) idx++;
      n_chk++;
      if ({tx[0], busy[0], cnt[0], rdy[0]} !== want(0)) begin
        n_err++; $display("FAIL fill cyc=%0d got=%b exp=%b", i, {tx[0], busy[0], cnt[0], rdy[0]}, want(0));
      end
      if (i == 19) begin
        n_chk++;
        if (idx != 5) begin n_err++; $display("FAIL fill_accepted got=%0d exp=5", idx); end
      end
    end
    v[0] = 1'b0;
    n_chk++;
    if (idx != 7 || busy[0] !== 1'b0) begin
      n_err++; $display("FAIL fill_drain got=%0d/%b exp=7/0", idx, busy[0]);
    end
  endtask

  task automatic test_push_on_pop();
    v[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin txd = 8'($urandom); step(); end
    v[0] = 1'b0;
    for (int i = 0; i < 60 && mc[0] != flen(0) - 1; i++) step();
    n_chk++;
    if (mc[0] != flen(0) - 1 || cnt[0] !== 3'd2) begin
      n_err++; $display("FAIL pop_edge_reached got=%0d/%0d exp=%0d/2", mc[0], cnt[0], flen(0) - 1);
    end
    txd = 8'($urandom); v[0] = 1'b1;
    step();
    v[0] = 1'b0;
    n_chk++;
    if (cnt[0] !== 3'd2) begin n_err++; $display("FAIL push_on_pop_count got=%0d exp=2", cnt[0]); end
    for (int i = 0; i < 130; i++) begin
      step();
      n_chk++;
      if ({tx[0], busy[0], cnt[0], rdy[0]} !== want(0)) begin
        n_err++; $display("FAIL push_on_pop cyc=%0d got=%b exp=%b", i, {tx[0], busy[0], cnt[0], rdy[0]}, want(0));
      end
    end
  endtask

  task automatic test_reset_mid();
    v[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin txd = 8'($urandom); step(); end
    v[0] = 1'b0;
    for (int i = 0; i < 20 && mc[0] != 10; i++) step();
    rst = 1'b1;
    #1;
    n_chk++;
    if (rdy[0] !== 1'b0) begin n_err++; $display("FAIL ready_in_reset got=%b exp=0", rdy[0]); end
    step();
    rst = 1'b0;
    n_chk++;
    if ({tx[0], busy[0], cnt[0]} !== 5'b10000) begin
      n_err++; $display("FAIL mid_reset got=%b exp=%b", {tx[0], busy[0], cnt[0]}, 5'b10000);
    end
    for (int i = 0; i < 60; i++) begin
      step();
      n_chk++;
      if ({tx[0], busy[0]} !== 2'b10) begin
        n_err++; $display("FAIL after_reset_quiet cyc=%0d got=%b exp=10", i, {tx[0], busy[0]});
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < 3; d++) v[d] = ($urandom_range(0, 9) < 2);
      txd = 8'($urandom);
      step();
      for (int d = 0; d < 3; d++) begin
        n_chk++;
        if ({tx[d], busy[d], cnt[d], rdy[d]} !== want(d)) begin
          n_err++; $display("FAIL random u%0d cyc=%0d got=%b exp=%b", d, i, {tx[d], busy[d], cnt[d], rdy[d]}, want(d));
        end
      end
    end
    for (int d = 0; d < 3; d++) v[d] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame_8n1();
    test_parity();
    test_back_to_back();
    test_fill();
    test_push_on_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
